// File: rtl/data_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_bus_responder
// Description : Memory-side responder for the core's data bus. Serves loads
//               combinationally from on-chip data RAM and an MMIO register
//               bank (LED, SW, SEG, CYCLE, TIMER, STATUS). Stores commit on
//               the rising clock edge. Handles byte/halfword lane steering,
//               load sign/zero extension and misalignment detection.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               mem_w           - store strobe
//               Addr_in         - byte address
//               Data_in         - store data (sub-word data in low bits)
//               DMType          - access type (word/half/byte, signedness)
//               Data_out        - combinational load data
//               sw_i            - switch inputs
//               led_o, seg_o    - LED and seven-segment registers
//               timer_irq_o     - timer expired flag (level)
// Revision    : 1.0 - initial release
// ============================================================================
module data_bus_responder #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic [31:0] Data_out,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic [31:0] seg_o,
    output logic        timer_irq_o
);

    localparam int          c_aw        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_ram_bytes = 32'(DEPTH_WORDS * 4);

    localparam logic [31:0] c_addr_led    = 32'hFFFF_0000;
    localparam logic [31:0] c_addr_sw     = 32'hFFFF_0004;
    localparam logic [31:0] c_addr_seg    = 32'hFFFF_0008;
    localparam logic [31:0] c_addr_cycle  = 32'hFFFF_0010;
    localparam logic [31:0] c_addr_timer  = 32'hFFFF_0014;
    localparam logic [31:0] c_addr_status = 32'hFFFF_0018;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [15:0] r_led;
    logic [31:0] r_seg;
    logic [31:0] r_cycle;
    logic [31:0] r_timer;
    logic [1:0]  r_status;   // [0] timer expired, [1] misalign error

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic w_is_word, w_is_half, w_is_byte, w_signed;

    always_comb begin
        w_is_word = 1'b0;
        w_is_half = 1'b0;
        w_is_byte = 1'b0;
        w_signed  = 1'b0;
        case (DMType)
            3'b001:  begin w_is_half = 1'b1; w_signed = 1'b1; end
            3'b010:  begin w_is_half = 1'b1; end
            3'b011:  begin w_is_byte = 1'b1; w_signed = 1'b1; end
            3'b100:  begin w_is_byte = 1'b1; end
            default: begin w_is_word = 1'b1; end
        endcase
    end

    logic            w_mmio_region;
    logic            w_misalign;
    logic            w_mis_event;
    logic            w_is_ram;
    logic [c_aw-1:0] w_ram_idx;

    assign w_mmio_region = (Addr_in[31:16] == 16'hFFFF);
    assign w_misalign    = (w_is_word && (Addr_in[1:0] != 2'b00)) ||
                           (w_is_half && Addr_in[0]);
    // Sub-word accesses into the MMIO window are silently ignored rather
    // than flagged, so only genuine alignment faults raise the error.
    assign w_mis_event   = w_misalign && !(w_mmio_region && !w_is_word);
    assign w_is_ram      = (Addr_in < c_ram_bytes);
    assign w_ram_idx     = Addr_in[c_aw+1:2];

    // ------------------------------------------------------------------
    // Store path
    // ------------------------------------------------------------------
    logic        w_ram_we;
    logic        w_mmio_wr;
    logic        w_wr_led, w_wr_seg, w_wr_timer, w_wr_status;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_ram_we    = mem_w && !rst && !w_misalign && w_is_ram;
    assign w_mmio_wr   = mem_w && w_is_word && !w_misalign;
    assign w_wr_led    = w_mmio_wr && (Addr_in == c_addr_led);
    assign w_wr_seg    = w_mmio_wr && (Addr_in == c_addr_seg);
    assign w_wr_timer  = w_mmio_wr && (Addr_in == c_addr_timer);
    assign w_wr_status = w_mmio_wr && (Addr_in == c_addr_status);

    // Sub-word data is replicated across all lanes; the byte enables pick
    // which lanes actually land in the RAM word.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = Data_in;
        if (w_is_half) begin
            w_be    = Addr_in[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{Data_in[15:0]}};
        end else if (w_is_byte) begin
            w_be    = 4'b0001 << Addr_in[1:0];
            w_wdata = {4{Data_in[7:0]}};
        end else begin
            w_be    = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_ram_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    logic       w_timer_expire;
    logic [1:0] w_status_clr;

    // A reload in the final count cycle pre-empts expiry.
    assign w_timer_expire = !w_wr_timer && (r_timer == 32'd1);
    assign w_status_clr   = w_wr_status ? Data_in[1:0] : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led    <= 16'h0000;
            r_seg    <= 32'h0000_0000;
            r_cycle  <= 32'h0000_0000;
            r_timer  <= 32'h0000_0000;
            r_status <= 2'b00;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_wr_led) begin
                r_led <= Data_in[15:0];
            end
            if (w_wr_seg) begin
                r_seg <= Data_in;
            end
            if (w_wr_timer) begin
                r_timer <= Data_in;
            end else if (r_timer != 32'd0) begin
                r_timer <= r_timer - 32'd1;
            end
            // Set events are OR-ed in after the clear so set wins.
            r_status <= (r_status & ~w_status_clr) | {w_mis_event, w_timer_expire};
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] w_rword;
    logic [15:0] w_rhalf;
    logic [7:0]  w_rbyte;
    logic [31:0] w_ram_rdata;

    assign w_rword = r_mem[w_ram_idx];
    assign w_rhalf = Addr_in[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        case (Addr_in[1:0])
            2'b00:   w_rbyte = w_rword[7:0];
            2'b01:   w_rbyte = w_rword[15:8];
            2'b10:   w_rbyte = w_rword[23:16];
            default: w_rbyte = w_rword[31:24];
        endcase
    end

    always_comb begin
        w_ram_rdata = w_rword;
        if (w_is_half) begin
            w_ram_rdata = {{16{w_signed & w_rhalf[15]}}, w_rhalf};
        end else if (w_is_byte) begin
            w_ram_rdata = {{24{w_signed & w_rbyte[7]}}, w_rbyte};
        end
    end

    always_comb begin
        Data_out = 32'h0000_0000;
        if (!w_misalign) begin
            if (w_is_ram) begin
                Data_out = w_ram_rdata;
            end else if (w_is_word) begin
                case (Addr_in)
                    c_addr_led:    Data_out = {16'h0000, r_led};
                    c_addr_sw:     Data_out = {16'h0000, sw_i};
                    c_addr_seg:    Data_out = r_seg;
                    c_addr_cycle:  Data_out = r_cycle;
                    c_addr_timer:  Data_out = r_timer;
                    c_addr_status: Data_out = {30'h0, r_status};
                    default:       Data_out = 32'h0000_0000;
                endcase
            end
        end
    end

    assign led_o       = r_led;
    assign seg_o       = r_seg;
    assign timer_irq_o = r_status[0];

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_data_bus_responder
// Description : Self-checking bench for data_bus_responder. Directed steps
//               followed by randomized traffic, checked against a byte-level
//               behavioural model of the memory map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_responder;

    localparam int DEPTH     = 64;
    localparam int RAM_BYTES = DEPTH * 4;

    localparam logic [31:0] LED  = 32'hFFFF_0000;
    localparam logic [31:0] SW   = 32'hFFFF_0004;
    localparam logic [31:0] SEG  = 32'hFFFF_0008;
    localparam logic [31:0] CYC  = 32'hFFFF_0010;
    localparam logic [31:0] TMR  = 32'hFFFF_0014;
    localparam logic [31:0] STAT = 32'hFFFF_0018;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [2:0]  DMType;
    logic [31:0] Data_out;
    logic [15:0] sw_i;
    logic [15:0] led_o;
    logic [31:0] seg_o;
    logic        timer_irq_o;

    always #5 clk = ~clk;

    data_bus_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_w      (mem_w),
        .Addr_in    (Addr_in),
        .Data_in    (Data_in),
        .DMType     (DMType),
        .Data_out   (Data_out),
        .sw_i       (sw_i),
        .led_o      (led_o),
        .seg_o      (seg_o),
        .timer_irq_o(timer_irq_o)
    );

    // Reference model: RAM as a flat little-endian byte array.
    logic [7:0]  m_ram [RAM_BYTES];
    logic [15:0] m_led;
    logic [31:0] m_seg, m_cyc, m_tmr;
    logic        m_exp, m_mis;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int acc_size(input logic [2:0] t);
        case (t)
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] t);
        int          sz;
        bit          sgn;
        logic [31:0] v;
        sz  = acc_size(t);
        sgn = (t == 3'd1) || (t == 3'd3);
        if (a < RAM_BYTES) begin
            if ((a % sz) != 0) return 32'h0;
            v = 32'h0;
            for (int k = 0; k < sz; k++) v = v | (32'(m_ram[a + k]) << (8 * k));
            if (sgn && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            return v;
        end
        if (sz != 4 || a[1:0] != 2'b00) return 32'h0;
        case (a)
            LED:     return {16'h0, m_led};
            SW:      return {16'h0, sw_i};
            SEG:     return m_seg;
            CYC:     return m_cyc;
            TMR:     return m_tmr;
            STAT:    return {30'h0, m_mis, m_exp};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        int         sz;
        bit         al, tw, xev;
        logic [1:0] clr;
        if (rst) begin
            m_led = 16'h0; m_seg = 32'h0; m_cyc = 32'h0; m_tmr = 32'h0;
            m_exp = 1'b0;  m_mis = 1'b0;
            return;
        end
        sz  = acc_size(DMType);
        al  = ((Addr_in % sz) == 0);
        tw  = 1'b0;
        clr = 2'b00;
        if (mem_w && al) begin
            if (Addr_in < RAM_BYTES) begin
                for (int k = 0; k < sz; k++) m_ram[Addr_in + k] = Data_in[8*k +: 8];
            end else if (sz == 4) begin
                case (Addr_in)
                    LED:  m_led = Data_in[15:0];
                    SEG:  m_seg = Data_in;
                    TMR:  tw = 1'b1;
                    STAT: clr = Data_in[1:0];
                    default: ;
                endcase
            end
        end
        xev = 1'b0;
        if (tw) begin
            m_tmr = Data_in;
        end else if (m_tmr != 0) begin
            xev   = (m_tmr == 32'd1);
            m_tmr = m_tmr - 32'd1;
        end
        m_exp = (m_exp & ~clr[0]) | xev;
        m_mis = (m_mis & ~clr[1]) | (!al && !(Addr_in[31:16] == 16'hFFFF && sz != 4));
        m_cyc = m_cyc + 32'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic mw, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] t);
        rst = r; mem_w = mw; Addr_in = a; Data_in = d; DMType = t;
        #2;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":dout"}, Data_out, m_load(Addr_in, DMType));
        chk({tag, ":led"},  {16'h0, led_o}, {16'h0, m_led});
        chk({tag, ":seg"},  seg_o, m_seg);
        chk({tag, ":irq"},  {31'h0, timer_irq_o}, {31'h0, m_exp});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  t;
        int          sel;

        rst = 1'b1; mem_w = 1'b0; Addr_in = CYC; Data_in = 32'h0; DMType = 3'd0;
        sw_i = 16'h0;
        @(posedge clk);
        #1;
        drive(1, 0, CYC, 0, 0); tick();
        drive(1, 0, CYC, 0, 0); tick();

        // Reset state
        drive(0, 0, CYC, 0, 0);
        chk("rst_cycle", Data_out, 32'h0);
        chk("rst_led",   {16'h0, led_o}, 32'h0);
        chk("rst_seg",   seg_o, 32'h0);
        chk("rst_irq",   {31'h0, timer_irq_o}, 32'h0);
        tick();

        // Fill RAM so every model byte is known
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 32'(i * 4), $urandom, 0);
            tick();
        end

        // Byte store lane steering and load extension
        drive(0, 1, 32'h10, 32'hDEAD_BEEF, 0); tick();
        drive(0, 1, 32'h11, 32'h5A, 3);
        chk("st_same_cycle_old", Data_out, 32'hFFFF_FFBE);
        tick();
        drive(0, 0, 32'h10, 0, 0); chk("ld_word_10", Data_out, 32'hDEAD_5AEF); tick();
        drive(0, 0, 32'h13, 0, 3); chk("ld_sbyte_13", Data_out, 32'hFFFF_FFDE); tick();
        drive(0, 0, 32'h13, 0, 4); chk("ld_ubyte_13", Data_out, 32'h0000_00DE); tick();

        // Halfword store/load
        drive(0, 1, 32'h22, 32'h8001, 1); tick();
        drive(0, 0, 32'h22, 0, 1); chk("ld_shalf_22", Data_out, 32'hFFFF_8001); tick();
        drive(0, 0, 32'h22, 0, 2); chk("ld_uhalf_22", Data_out, 32'h0000_8001); tick();
        drive(0, 0, 32'h20, 0, 0);
        chk("ld_word20_hi", {16'h0, Data_out[31:16]}, 32'h0000_8001);
        check_all("ld_word20");
        tick();

        // Misaligned word store
        drive(0, 1, 32'h06, 32'h1111_1111, 0); chk("mis_ld_zero", Data_out, 32'h0); tick();
        drive(0, 0, 32'h04, 0, 0); check_all("mis_ram_unchanged"); tick();
        drive(0, 0, STAT, 0, 0); chk("stat_mis", Data_out, 32'h2); tick();
        drive(0, 1, STAT, 32'h2, 0); tick();
        drive(0, 0, STAT, 0, 0); chk("stat_mis_clr", Data_out, 32'h0); tick();

        // Timer countdown and expiry
        drive(0, 1, TMR, 32'd3, 0); tick();
        for (int j = 0; j < 4; j++) begin
            drive(0, 0, TMR, 0, 0);
            chk("tmr_count", Data_out, 32'(3 - j));
            chk("tmr_irq",   {31'h0, timer_irq_o}, (j == 3) ? 32'h1 : 32'h0);
            tick();
        end
        drive(0, 1, STAT, 32'h1, 0); tick();
        drive(0, 0, STAT, 0, 0); chk("irq_w1c", {31'h0, timer_irq_o}, 32'h0); tick();

        // W1C in the expiry cycle: set wins
        drive(0, 1, TMR, 32'd2, 0); tick();
        drive(0, 0, TMR, 0, 0); tick();
        drive(0, 1, STAT, 32'h1, 0); tick();
        drive(0, 0, STAT, 0, 0);
        chk("w1c_race_stat", Data_out, 32'h1);
        chk("w1c_race_irq",  {31'h0, timer_irq_o}, 32'h1);
        tick();
        drive(0, 1, STAT, 32'h1, 0); tick();

        // Reload in the final count cycle suppresses expiry
        drive(0, 1, TMR, 32'd1, 0); tick();
        drive(0, 1, TMR, 32'd5, 0); tick();
        drive(0, 0, TMR, 0, 0);
        chk("tmr_reload_cnt", Data_out, 32'd5);
        chk("tmr_reload_irq", {31'h0, timer_irq_o}, 32'h0);
        tick();

        // LED / SW / SEG
        drive(0, 1, LED, 32'h1234_ABCD, 0); tick();
        sw_i = 16'h00F0;
        drive(0, 0, SW, 0, 0);
        chk("led_val", {16'h0, led_o}, 32'h0000_ABCD);
        chk("sw_load", Data_out, 32'h0000_00F0);
        tick();
        drive(0, 1, SEG, 32'hCAFE_F00D, 0); tick();

        // Reset beats a simultaneous store; RAM retained
        drive(1, 1, LED, 32'hFFFF, 0); chk("seg_val", seg_o, 32'hCAFE_F00D); tick();
        drive(0, 0, CYC, 0, 0);
        chk("rst2_cycle", Data_out, 32'h0);
        chk("rst2_led",   {16'h0, led_o}, 32'h0);
        chk("rst2_seg",   seg_o, 32'h0);
        chk("rst2_irq",   {31'h0, timer_irq_o}, 32'h0);
        tick();
        drive(0, 0, 32'h10, 0, 0); chk("ram_retained", Data_out, 32'hDEAD_5AEF); tick();

        // CYCLE is read-only; unmapped address reads 0
        drive(0, 1, CYC, 32'hFFFF_FFFF, 0); chk("cyc_before_st", Data_out, 32'd2); tick();
        drive(0, 0, CYC, 0, 0); chk("cyc_ro_a", Data_out, 32'd3); tick();
        drive(0, 0, CYC, 0, 0); chk("cyc_ro_b", Data_out, 32'd4); tick();
        drive(0, 0, 32'h8000_0000, 0, 0); chk("unmapped", Data_out, 32'h0); tick();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            sel  = int'($urandom_range(0, 9));
            sw_i = 16'($urandom);
            d    = $urandom;
            t    = 3'($urandom_range(0, 7));
            if (sel < 6) begin
                a = 32'($urandom_range(0, RAM_BYTES - 1));
            end else if (sel < 9) begin
                a = 32'hFFFF_0000 + 32'(4 * $urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
                if ($urandom_range(0, 9) < 7) t = 3'd0;
                if (a == TMR) d = 32'($urandom_range(0, 6));
            end else begin
                a = $urandom;
            end
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4), a, d, t);
            check_all("rnd");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_bus_responder.md
# data_bus_responder

Memory-side responder for the pipelined core's data bus. The core drives address, store data, write strobe and access type from its MEM stage and expects load data back in the same cycle. This block provides that response from on-chip data RAM and a small MMIO register bank: LEDs, switches, seven-segment data, a free-running cycle counter, and a one-shot countdown timer. It handles byte/halfword/word lane steering, sign/zero extension of loads, and misalignment detection.

## Interface
- DEPTH_WORDS, 1024: data RAM size in 32-bit words; power of two; RAM occupies byte addresses 0 .. DEPTH_WORDS*4-1.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_w  in  1  store strobe; high for exactly the cycles a store is in MEM.
- Addr_in  in  32  byte address.
- Data_in  in  32  store data; byte/halfword taken from low bits.
- DMType  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; other codes treated as word.
- Data_out  out  32  load data, combinational from current state and Addr_in/DMType.
- sw_i  in  16  switch inputs.
- led_o  out  16  LED register.
- seg_o  out  32  seven-segment display data register.
- timer_irq_o  out  1  timer expired flag (level).

## Operation
- Address decode: RAM if Addr_in < DEPTH_WORDS*4. MMIO word registers at:
  - 0xFFFF_0000 LED (R/W, low 16 bits)
  - 0xFFFF_0004 SW (RO; {16'b0, sw_i})
  - 0xFFFF_0008 SEG (R/W)
  - 0xFFFF_0010 CYCLE (RO)
  - 0xFFFF_0014 TIMER (R/W, current count)
  - 0xFFFF_0018 STATUS (bit0 expired, bit1 misalign error; W1C)
- Any other address: loads return 0, stores ignored.
- Alignment: word needs Addr_in[1:0]==0; half needs Addr_in[0]==0; byte is always aligned. A misaligned access suppresses the store, returns 0 on load, and sets STATUS[1]. This is evaluated every cycle, so loads also set it. MMIO registers accept word accesses only. Non-word accesses to MMIO are ignored and read 0, with no error.
- RAM store: byte enables from DMType and Addr_in[1:0]. Byte goes to lane Addr_in[1:0]; half goes to lanes {Addr_in[1],0} and +1. Other bytes are untouched.
- RAM load: select lane(s) by Addr_in[1:0]. Sign-extend for 001/011, zero-extend for 010/100. Reads have no side effects.
- CYCLE: increments by 1 every cycle and wraps at 2^32.
- TIMER: a store loads the count. Otherwise, while nonzero, it decrements by 1 per cycle. On the 1→0 transition it sets STATUS[0]. Storing 0 stops the timer without setting the flag.
- STATUS write: bits of Data_in that are 1 clear the corresponding flags. If a set event and a clear happen in the same cycle, set wins.
- timer_irq_o = STATUS[0].

## Timing
- Loads: zero latency. Data_out is valid in the same cycle as Addr_in/DMType.
- Stores: commit on the rising edge where mem_w=1.
- A load to the same address in the cycle of a store returns the old value. The new value is visible the next cycle.
- Reset (rst high at edge): LED, SEG, CYCLE, TIMER and STATUS all become 0; led_o=0, seg_o=0, timer_irq_o=0. RAM contents are not cleared.
- Reset has priority over a simultaneous store.
- A TIMER store in the cycle the count would reach 0 reloads the count and does not set the flag.
- CYCLE reads the pre-increment value. Reading CYCLE in two consecutive cycles returns consecutive values.

## Test plan
- Word store 0xDEADBEEF at 0x10, then byte store 0x5A at 0x11 → word load at 0x10 = 0xDEAD5AEF; signed byte load at 0x13 = 0xFFFFFFDE; unsigned byte load at 0x13 = 0x000000DE.
- Half store 0x8001 at 0x22 → signed half load at 0x22 = 0xFFFF8001; unsigned half load at 0x22 = 0x00008001; word load at 0x20 shows the upper half = 0x8001.
- Word store at 0x06 → RAM unchanged, load at 0x06 returns 0, STATUS reads 0x2; write 0x2 to STATUS → STATUS reads 0.
- Store 3 to TIMER → reads 3,2,1,0 on consecutive cycles; timer_irq_o rises when the count reaches 0; a W1C to STATUS clears it; a W1C issued in the expiry cycle leaves the flag set.
- LED store 0x1234ABCD → led_o=0xABCD; sw_i=0x00F0 → SW load returns 0x000000F0; assert rst → led_o=0, seg_o=0, CYCLE reads 0 the cycle after reset release, RAM data retained.
- Store 0xFFFFFFFF to CYCLE (RO) → ignored and counting continues; load from 0x8000_0000 → 0.
